// File: rtl/led_chaser.sv
// -----------------------------------------------------------------------------
// led_chaser
//
// Turns the board's blink-rate square wave (flash) into an LED status display.
// Every rising edge of flash advances a pattern sequencer (rotate, bounce,
// binary count or blink). The pattern is then gated by a PWM brightness stage
// and registered onto the LED bank.
//
// Configuration macro: LED_CHASER_PWM_EN
//   defined   -> free-running pwm_cnt and brightness gating of the LEDs
//   undefined -> brightness is ignored and leds follow the pattern directly
//
// Parameters:
//   LED_W       number of LEDs (2..16)
//   PWM_W       width of the PWM counter and brightness input
//
// Ports:
//   in_clk      system clock, shared with the flash producer
//   reset       synchronous, active-high reset
//   flash       blink-rate square wave; each rising edge is one step
//   mode        0 rotate, 1 bounce, 2 binary count, 3 blink
//   pause       while high, flash rising edges are dropped
//   brightness  PWM duty; 0 = off, all-ones = fully on
//   leds        registered LED drive, active-high
//   step_pulse  one-cycle pulse per executed step
//   wrap        one-cycle pulse with step_pulse when a pattern cycle completes
// -----------------------------------------------------------------------------
module led_chaser #(
  parameter int LED_W = 8,
  parameter int PWM_W = 4
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             flash,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic [PWM_W-1:0] brightness,
  output logic [LED_W-1:0] leds,
  output logic             step_pulse,
  output logic             wrap
);

  localparam int POS_W = $clog2(LED_W);
  localparam logic [LED_W-1:0] PAT_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_ALL  = '1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic             flash_r_q, flash_r_d;
  logic             flash_rr_q, flash_rr_d;
  mode_e            mode_q, mode_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_down_q, dir_down_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             step_pulse_q, step_pulse_d;
  logic             wrap_q, wrap_d;

  logic             rise;
  logic             step;
  mode_e            mode_in;

  assign mode_in = mode_e'(mode);

`ifdef LED_CHASER_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_on;
`else
  logic             unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // Edge detect, pattern sequencing and LED drive. A step only happens on a
  // flash rise while not paused; a mode change consumes that step to load the
  // new mode's starting pattern, so it never reports a wrap.
  always_comb begin
    flash_r_d    = flash;
    flash_rr_d   = flash_r_q;
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    pos_d        = pos_q;
    dir_down_d   = dir_down_q;
    wrap_d       = 1'b0;

    rise         = flash_r_q & ~flash_rr_q;
    step         = rise & ~pause;
    step_pulse_d = step;

    if (step) begin
      if (mode_in != mode_q) begin
        mode_d     = mode_in;
        pos_d      = '0;
        dir_down_d = 1'b0;
        case (mode_in)
          MODE_ROTATE: pattern_d = PAT_ONE;
          MODE_BOUNCE: pattern_d = PAT_ONE;
          MODE_COUNT:  pattern_d = '0;
          MODE_BLINK:  pattern_d = PAT_ALL;
          default:     pattern_d = PAT_ONE;
        endcase
      end else begin
        case (mode_q)
          MODE_ROTATE: begin
            pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            wrap_d    = (pattern_d == PAT_ONE);
          end
          MODE_BOUNCE: begin
            // Direction flips on arrival at an endpoint, so each endpoint is
            // displayed for exactly one step.
            if (!dir_down_q) begin
              pos_d = pos_q + POS_W'(1);
              if (pos_d == POS_LAST) dir_down_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
              if (pos_d == '0) begin
                dir_down_d = 1'b0;
                wrap_d     = 1'b1;
              end
            end
            pattern_d = PAT_ONE << pos_d;
          end
          MODE_COUNT: begin
            pattern_d = pattern_q + PAT_ONE;
            wrap_d    = (pattern_q == PAT_ALL);
          end
          MODE_BLINK: begin
            if (pattern_q == PAT_ALL) begin
              pattern_d = '0;
              wrap_d    = 1'b1;
            end else begin
              pattern_d = PAT_ALL;
            end
          end
          default: pattern_d = pattern_q;
        endcase
      end
    end

`ifdef LED_CHASER_PWM_EN
    // All-ones brightness is forced fully on; otherwise the duty is
    // brightness out of 2^PWM_W cycles.
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_on    = (brightness == '1) | (pwm_cnt_q < brightness);
    leds_d    = pattern_q & {LED_W{pwm_on}};
`else
    leds_d    = pattern_q;
`endif
  end

  // State registers. The edge-detect flops reset high so a flash that is
  // already high when reset releases does not look like a rise.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      flash_r_q    <= 1'b1;
      flash_rr_q   <= 1'b1;
      mode_q       <= MODE_ROTATE;
      pattern_q    <= PAT_ONE;
      pos_q        <= '0;
      dir_down_q   <= 1'b0;
      leds_q       <= '0;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
`ifdef LED_CHASER_PWM_EN
      pwm_cnt_q    <= '0;
`endif
    end else begin
      flash_r_q    <= flash_r_d;
      flash_rr_q   <= flash_rr_d;
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      pos_q        <= pos_d;
      dir_down_q   <= dir_down_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
`ifdef LED_CHASER_PWM_EN
      pwm_cnt_q    <= pwm_cnt_d;
`endif
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_pulse_q;
  assign wrap       = wrap_q;

endmodule
